// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared aluop codes, exception codes, FSM states and op-class helpers for the LSU
package mem_lsu_pkg;
  localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  typedef enum logic [1:0] {EXCP_NONE, EXCP_ADEL, EXCP_ADES, EXCP_BUSERR} excp_t;
  typedef enum logic {LSU_IDLE, LSU_REQ} lsu_state_t;
  function automatic logic is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction
  function automatic logic is_mem(input logic [7:0] op);
    return is_store(op) || (op inside {EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP});
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane select/replication, load lane extract with sign/zero extension, misalign detect
module mem_align
  import mem_lsu_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);
  logic byte_op, half_op, word_op;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  assign byte_op = op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
  assign half_op = op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
  assign word_op = op inside {EXE_LW_OP, EXE_SW_OP};
  assign lane_b = rdata[{lane, 3'b000} +: 8];
  assign lane_h = lane[1] ? rdata[31:16] : rdata[15:0];
  assign sel = byte_op ? 4'b0001 << lane : half_op ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata = byte_op ? {4{sdata[7:0]}} : half_op ? {2{sdata[15:0]}} : sdata;
  assign misalign = (half_op & lane[0]) | (word_op & |lane);
  always_comb begin
    ldata = rdata;
    ldata = op == EXE_LB_OP  ? {{24{lane_b[7]}}, lane_b} :
            op == EXE_LBU_OP ? {24'b0, lane_b} :
            op == EXE_LH_OP  ? {{16{lane_h[15]}}, lane_h} :
            op == EXE_LHU_OP ? {16'b0, lane_h} : rdata;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving a req/ack data bus, with pipeline stall and fault reporting
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  aluop_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  input  logic        flush_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_err_i,
  output logic        stall_req_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [1:0]  excp_o
);
  lsu_state_t state;
  logic [7:0] op_q, cnt, cur_op;
  logic [31:0] addr_q, sdata_q, cur_sdata, ldata, wdata_al;
  logic [4:0] wd_q;
  logic [3:0] sel;
  logic [1:0] cur_lane;
  logic wreg_q, kill_q, misalign, in_req, live, fault, done, kill;
  assign in_req = state == LSU_REQ;
  assign cur_op = in_req ? op_q : aluop_i;
  assign cur_lane = in_req ? addr_q[1:0] : mem_addr_i[1:0];
  assign cur_sdata = in_req ? sdata_q : mem_sdata_i;
  mem_align u_align (
    .op(cur_op), .lane(cur_lane), .sdata(cur_sdata), .rdata(dbus_rdata_i),
    .sel(sel), .wdata(wdata_al), .ldata(ldata), .misalign(misalign)
  );
  assign live = valid_i & ~flush_i;
  assign fault = dbus_err_i | (cnt == 8'(BUS_TIMEOUT));
  assign done = dbus_ack_i | fault;
  assign kill = kill_q | flush_i;
  assign dbus_req_o = in_req;
  assign dbus_we_o = in_req & is_store(op_q);
  assign dbus_sel_o = in_req ? sel : 4'b0;
  assign dbus_addr_o = in_req ? {addr_q[31:2], 2'b00} : 32'b0;
  assign dbus_wdata_o = in_req ? wdata_al : 32'b0;
  assign stall_req_o = in_req ? ~done : live & is_mem(aluop_i) & ~misalign;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LSU_IDLE;
      cnt <= '0;
      op_q <= '0;
      addr_q <= '0;
      sdata_q <= '0;
      wd_q <= '0;
      wreg_q <= 1'b0;
      kill_q <= 1'b0;
      wd_o <= '0;
      wreg_o <= 1'b0;
      wdata_o <= '0;
      excp_o <= EXCP_NONE;
    end else if (in_req) begin
      wreg_o <= 1'b0;
      excp_o <= EXCP_NONE;
      kill_q <= kill;
      cnt <= cnt == 8'hFF ? cnt : cnt + 8'd1;
      if (done) begin
        state <= LSU_IDLE;
        wd_o <= wd_q;
        wdata_o <= ldata;
        wreg_o <= wreg_q & ~fault & ~kill & ~is_store(op_q);
        excp_o <= fault & ~kill ? EXCP_BUSERR : EXCP_NONE;
      end
    end else begin
      wd_o <= wd_i;
      wdata_o <= wdata_i;
      wreg_o <= live & wreg_i & ~is_mem(aluop_i);
      excp_o <= EXCP_NONE;
      if (live & is_mem(aluop_i) & misalign)
        excp_o <= is_store(aluop_i) ? EXCP_ADES : EXCP_ADEL;
      else if (live & is_mem(aluop_i)) begin
        state <= LSU_REQ;
        cnt <= '0;
        kill_q <= 1'b0;
        op_q <= aluop_i;
        addr_q <= mem_addr_i;
        sdata_q <= mem_sdata_i;
        wd_q <= wd_i;
        wreg_q <= wreg_i;
      end
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed checks of ALU forwarding, loads, stores, faults, flush and async reset
module tb_mem_lsu;
  import mem_lsu_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic valid_i = 1'b0, wreg_i = 1'b0, flush_i = 1'b0, dbus_ack_i = 1'b0, dbus_err_i = 1'b0;
  logic [7:0] aluop_i = '0;
  logic [4:0] wd_i = '0;
  logic [31:0] wdata_i = '0, mem_addr_i = '0, mem_sdata_i = '0, dbus_rdata_i = '0;
  logic dbus_req_o, dbus_we_o, stall_req_o, wreg_o;
  logic [3:0] dbus_sel_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, wdata_o;
  logic [4:0] wd_o;
  logic [1:0] excp_o;
  int total = 0, passed = 0;
  int stalls, reqs;
  logic stable, first_we;
  logic [3:0] first_sel;
  logic [31:0] first_addr, first_wdata;

  mem_lsu dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i), .flush_i(flush_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_sel_o(dbus_sel_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
    .dbus_err_i(dbus_err_i), .stall_req_o(stall_req_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .excp_o(excp_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // mode: 0 ack, 1 err, 2 ack+err together; waits<0 never terminates (timeout)
  task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rd, input int waits, input int mode, input logic fl);
    int n;
    logic fin;
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; mem_sdata_i = sd;
    wd_i = 5'd9; wreg_i = 1'b1; dbus_rdata_i = rd;
    #1 stalls = stall_req_o ? 1 : 0;
    @(negedge clk);
    first_sel = dbus_sel_o; first_wdata = dbus_wdata_o; first_addr = dbus_addr_o; first_we = dbus_we_o;
    stable = 1'b1; reqs = 0; flush_i = fl; fin = 1'b0; n = 0;
    while (!fin && n < 400) begin
      dbus_ack_i = (n == waits) && mode != 1;
      dbus_err_i = (n == waits) && mode != 0;
      #1;
      if (dbus_req_o) reqs++;
      if (dbus_sel_o !== first_sel || dbus_wdata_o !== first_wdata || dbus_addr_o !== first_addr || dbus_we_o !== first_we)
        stable = 1'b0;
      if (stall_req_o) stalls++;
      else fin = 1'b1;
      @(negedge clk);
      n++;
    end
    dbus_ack_i = 1'b0; dbus_err_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    chk("terminated", {31'b0, fin}, 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_req", {31'b0, dbus_req_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_req_o}, 32'd0);
    chk("rst_wreg", {31'b0, wreg_o}, 32'd0);
    chk("rst_excp", {30'b0, excp_o}, 32'd0);
    @(negedge clk); rst = 1'b1;
    // ALU forwarding
    valid_i = 1'b1; aluop_i = EXE_OR_OP; wdata_i = 32'h1234; wd_i = 5'd5; wreg_i = 1'b1;
    #1 chk("add_stall", {31'b0, stall_req_o}, 32'd0);
    @(negedge clk);
    chk("add_wd", {27'b0, wd_o}, 32'd5);
    chk("add_wreg", {31'b0, wreg_o}, 32'd1);
    chk("add_wdata", wdata_o, 32'h1234);
    chk("add_excp", {30'b0, excp_o}, 32'd0);
    valid_i = 1'b0;
    @(negedge clk);
    chk("bubble_wreg", {31'b0, wreg_o}, 32'd0);
    // loads
    run_mem(EXE_LB_OP, 32'h103, 32'h0, 32'h80FF_FF00, 0, 0, 1'b0);
    chk("lb_sel", {28'b0, first_sel}, 32'b1000);
    chk("lb_addr", first_addr, 32'h100);
    chk("lb_we", {31'b0, first_we}, 32'd0);
    chk("lb_stalls", stalls, 32'd1);
    chk("lb_wdata", wdata_o, 32'hFFFF_FF80);
    chk("lb_wreg", {31'b0, wreg_o}, 32'd1);
    chk("lb_wd", {27'b0, wd_o}, 32'd9);
    chk("lb_req_drop", {31'b0, dbus_req_o}, 32'd0);
    run_mem(EXE_LHU_OP, 32'h102, 32'h0, 32'h8001_0000, 0, 0, 1'b0);
    chk("lhu_sel", {28'b0, first_sel}, 32'b1100);
    chk("lhu_wdata", wdata_o, 32'h0000_8001);
    run_mem(EXE_LH_OP, 32'h102, 32'h0, 32'h8001_0000, 0, 0, 1'b0);
    chk("lh_wdata", wdata_o, 32'hFFFF_8001);
    run_mem(EXE_LBU_OP, 32'h101, 32'h0, 32'h0000_A500, 0, 0, 1'b0);
    chk("lbu_sel", {28'b0, first_sel}, 32'b0010);
    chk("lbu_wdata", wdata_o, 32'h0000_00A5);
    run_mem(EXE_LW_OP, 32'h104, 32'h0, 32'hDEAD_BEEF, 1, 0, 1'b0);
    chk("lw_sel", {28'b0, first_sel}, 32'b1111);
    chk("lw_wdata", wdata_o, 32'hDEAD_BEEF);
    chk("lw_stalls", stalls, 32'd2);
    // stores
    run_mem(EXE_SH_OP, 32'h200, 32'hAABB_CCDD, 32'h0, 3, 0, 1'b0);
    chk("sh_stalls", stalls, 32'd4);
    chk("sh_wdata", first_wdata, 32'hCCDD_CCDD);
    chk("sh_sel", {28'b0, first_sel}, 32'b0011);
    chk("sh_we", {31'b0, first_we}, 32'd1);
    chk("sh_stable", {31'b0, stable}, 32'd1);
    chk("sh_wreg", {31'b0, wreg_o}, 32'd0);
    chk("sh_excp", {30'b0, excp_o}, 32'd0);
    run_mem(EXE_SB_OP, 32'h202, 32'h1122_3344, 32'h0, 0, 0, 1'b0);
    chk("sb_sel", {28'b0, first_sel}, 32'b0100);
    chk("sb_wdata", first_wdata, 32'h4444_4444);
    run_mem(EXE_SW_OP, 32'h300, 32'h1122_3344, 32'h0, 0, 0, 1'b0);
    chk("sw_sel", {28'b0, first_sel}, 32'b1111);
    chk("sw_wdata", first_wdata, 32'h1122_3344);
    // misalignment
    valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h101; wreg_i = 1'b1;
    #1 chk("lw_mis_stall", {31'b0, stall_req_o}, 32'd0);
    @(negedge clk);
    chk("lw_mis_req", {31'b0, dbus_req_o}, 32'd0);
    chk("lw_mis_excp", {30'b0, excp_o}, 32'd1);
    chk("lw_mis_wreg", {31'b0, wreg_o}, 32'd0);
    aluop_i = EXE_SW_OP; mem_addr_i = 32'h102;
    @(negedge clk);
    chk("sw_mis_excp", {30'b0, excp_o}, 32'd2);
    chk("sw_mis_req", {31'b0, dbus_req_o}, 32'd0);
    aluop_i = EXE_SH_OP; mem_addr_i = 32'h203;
    @(negedge clk);
    chk("sh_mis_excp", {30'b0, excp_o}, 32'd2);
    valid_i = 1'b0;
    @(negedge clk);
    chk("mis_clear", {30'b0, excp_o}, 32'd0);
    // bus faults
    run_mem(EXE_LW_OP, 32'h104, 32'h0, 32'h0, 2, 1, 1'b0);
    chk("err_excp", {30'b0, excp_o}, 32'd3);
    chk("err_wreg", {31'b0, wreg_o}, 32'd0);
    run_mem(EXE_LW_OP, 32'h104, 32'h0, 32'h5, 0, 2, 1'b0);
    chk("ackerr_excp", {30'b0, excp_o}, 32'd3);
    chk("ackerr_wreg", {31'b0, wreg_o}, 32'd0);
    run_mem(EXE_LW_OP, 32'h108, 32'h0, 32'h0, -1, 0, 1'b0);
    chk("to_excp", {30'b0, excp_o}, 32'd3);
    chk("to_stalls", stalls, 32'd256);
    chk("to_reqs", reqs, 32'd256);
    // flush
    run_mem(EXE_LW_OP, 32'h104, 32'h0, 32'h1234_5678, 1, 0, 1'b1);
    chk("fl_ld_wreg", {31'b0, wreg_o}, 32'd0);
    chk("fl_ld_stalls", stalls, 32'd2);
    run_mem(EXE_SW_OP, 32'h104, 32'h0, 32'h0, 1, 1, 1'b1);
    chk("fl_err_excp", {30'b0, excp_o}, 32'd0);
    chk("fl_st_we", {31'b0, first_we}, 32'd1);
    chk("fl_st_reqs", reqs, 32'd2);
    valid_i = 1'b1; flush_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h100;
    #1 chk("fl_idle_stall", {31'b0, stall_req_o}, 32'd0);
    @(negedge clk);
    chk("fl_idle_req", {31'b0, dbus_req_o}, 32'd0);
    aluop_i = EXE_OR_OP;
    @(negedge clk);
    chk("fl_idle_wreg", {31'b0, wreg_o}, 32'd0);
    flush_i = 1'b0; valid_i = 1'b0;
    // async reset mid-request
    valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h100;
    @(negedge clk);
    valid_i = 1'b0;
    chk("ar_req_before", {31'b0, dbus_req_o}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("ar_req", {31'b0, dbus_req_o}, 32'd0);
    chk("ar_stall", {31'b0, stall_req_o}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("ar_idle", {31'b0, dbus_req_o}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
